// File: rtl/stage_3.sv
// stage_3: execute/write-back stage. ALU ops plus an optional shift-add multiplier.
// Define STAGE3_MUL_EN to build the 16-cycle multiplier; without it opcode 0x08 is illegal.
module stage_3 (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] AIn,
  input  logic [15:0] BIn,
  input  logic [15:0] DestIn,
  input  logic [7:0]  OpIn,
  output logic        busy,
  output logic        done,
  output logic        MemWrite,
  output logic [15:0] MemAddr,
  output logic [15:0] MemData,
  output logic [15:0] ResultValue,
  output logic        ZeroFlag,
  output logic        CarryFlag,
  output logic        Illegal
);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_AND = 8'h03;
  localparam logic [7:0] OP_OR  = 8'h04;
  localparam logic [7:0] OP_XOR = 8'h05;
  localparam logic [7:0] OP_SHL = 8'h06;
  localparam logic [7:0] OP_SHR = 8'h07;
`ifdef STAGE3_MUL_EN
  localparam logic [7:0] OP_MUL = 8'h08;
`endif
  localparam logic [7:0] OP_MOV = 8'h09;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
`ifdef STAGE3_MUL_EN
    ST_MUL,
`endif
    ST_WRITE
  } state_t;

  state_t      state;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [15:0] dest_r;
  logic [7:0]  op_r;
  logic [15:0] res;

  logic [16:0] sum;
  logic [15:0] alu_res;
  logic        alu_carry;
  logic        alu_writes;
  logic        alu_illegal;

`ifdef STAGE3_MUL_EN
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic [15:0] mul_sum;

  assign mul_sum = acc + (b_r[0] ? a_r : '0);
`endif

  assign MemAddr     = dest_r;
  assign MemData     = res;
  assign ResultValue = res;

  always_comb begin
    sum         = {1'b0, a_r} + {1'b0, b_r};
    alu_res     = res;
    alu_carry   = 1'b0;
    alu_writes  = 1'b1;
    alu_illegal = 1'b0;
    case (op_r)
      OP_NOP: alu_writes = 1'b0;
      OP_ADD: begin
        alu_res   = sum[15:0];
        alu_carry = sum[16];
      end
      OP_SUB: begin
        alu_res   = a_r - b_r;
        alu_carry = (a_r < b_r);
      end
      OP_AND: alu_res = a_r & b_r;
      OP_OR:  alu_res = a_r | b_r;
      OP_XOR: alu_res = a_r ^ b_r;
      OP_SHL: alu_res = a_r << b_r[3:0];
      OP_SHR: alu_res = a_r >> b_r[3:0];
`ifdef STAGE3_MUL_EN
      OP_MUL: alu_res = res;
`endif
      OP_MOV: alu_res = a_r;
      default: begin
        alu_writes  = 1'b0;
        alu_illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= ST_IDLE;
      a_r       <= '0;
      b_r       <= '0;
      dest_r    <= '0;
      op_r      <= '0;
      res       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      MemWrite  <= 1'b0;
      Illegal   <= 1'b0;
      ZeroFlag  <= 1'b0;
      CarryFlag <= 1'b0;
`ifdef STAGE3_MUL_EN
      acc       <= '0;
      cnt       <= '0;
`endif
    end else begin
      done     <= 1'b0;
      MemWrite <= 1'b0;
      Illegal  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_r    <= AIn;
            b_r    <= BIn;
            dest_r <= DestIn;
            op_r   <= OpIn;
            busy   <= 1'b1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
`ifdef STAGE3_MUL_EN
          if (op_r == OP_MUL) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ST_MUL;
          end else
`endif
          begin
            if (alu_writes) begin
              res       <= alu_res;
              ZeroFlag  <= (alu_res == '0);
              CarryFlag <= alu_carry;
            end
            MemWrite <= alu_writes;
            Illegal  <= alu_illegal;
            done     <= 1'b1;
            state    <= ST_WRITE;
          end
        end
`ifdef STAGE3_MUL_EN
        ST_MUL: begin
          // Final step folds the last partial product straight into the result register.
          a_r <= {a_r[14:0], 1'b0};
          b_r <= {1'b0, b_r[15:1]};
          if (cnt == 4'd15) begin
            res       <= mul_sum;
            ZeroFlag  <= (mul_sum == '0);
            CarryFlag <= 1'b0;
            MemWrite  <= 1'b1;
            done      <= 1'b1;
            state     <= ST_WRITE;
          end else begin
            acc <= mul_sum;
            cnt <= cnt + 4'd1;
          end
        end
`endif
        ST_WRITE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_3.sv
// Directed self-checking bench for stage_3; exercises the multiplier when STAGE3_MUL_EN is defined.
module tb_stage_3;

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] AIn;
  logic [15:0] BIn;
  logic [15:0] DestIn;
  logic [7:0]  OpIn;
  logic        busy;
  logic        done;
  logic        MemWrite;
  logic [15:0] MemAddr;
  logic [15:0] MemData;
  logic [15:0] ResultValue;
  logic        ZeroFlag;
  logic        CarryFlag;
  logic        Illegal;

  int n_checks = 0;
  int n_fail   = 0;

  stage_3 dut (
    .CLK(CLK), .reset(reset), .start(start),
    .AIn(AIn), .BIn(BIn), .DestIn(DestIn), .OpIn(OpIn),
    .busy(busy), .done(done), .MemWrite(MemWrite),
    .MemAddr(MemAddr), .MemData(MemData), .ResultValue(ResultValue),
    .ZeroFlag(ZeroFlag), .CarryFlag(CarryFlag), .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present operands and pulse start across one edge; returns in cycle 1 (EXEC).
  task automatic issue(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] d);
    OpIn = op; AIn = a; BIn = b; DestIn = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    AIn = '0; BIn = '0; DestIn = '0; OpIn = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if ({busy, done, MemWrite, Illegal, ZeroFlag, CarryFlag} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, MemWrite, Illegal, ZeroFlag, CarryFlag});
    end
    n_checks++;
    if ({MemAddr, MemData, ResultValue} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h expected 0000 0000 0000", MemAddr, MemData, ResultValue);
    end
  endtask

  task automatic test_add();
    issue(8'h01, 16'hFFFF, 16'h0001, 16'h0040);
    n_checks++;
    if ({busy, done, MemWrite} !== 3'b100) begin
      n_fail++;
      $display("FAIL add_cycle1: busy/done/we got %b expected 100", {busy, done, MemWrite});
    end
    tick();
    n_checks++;
    if ({busy, done, MemWrite, Illegal} !== 4'b1110) begin
      n_fail++;
      $display("FAIL add_write_strobe: busy/done/we/ill got %b expected 1110", {busy, done, MemWrite, Illegal});
    end
    n_checks++;
    if (MemAddr !== 16'h0040) begin
      n_fail++;
      $display("FAIL add_addr: got %h expected 0040", MemAddr);
    end
    n_checks++;
    if (MemData !== 16'h0000) begin
      n_fail++;
      $display("FAIL add_data: got %h expected 0000", MemData);
    end
    n_checks++;
    if ({ZeroFlag, CarryFlag} !== 2'b11) begin
      n_fail++;
      $display("FAIL add_flags: z/c got %b expected 11", {ZeroFlag, CarryFlag});
    end
    tick();
    n_checks++;
    if ({busy, done, MemWrite} !== 3'b000) begin
      n_fail++;
      $display("FAIL add_idle: busy/done/we got %b expected 000", {busy, done, MemWrite});
    end
  endtask

  task automatic test_back_to_back();
    issue(8'h02, 16'h0003, 16'h0005, 16'h0041);
    tick();
    n_checks++;
    if ({MemWrite, MemData, ZeroFlag, CarryFlag} !== {1'b1, 16'hFFFE, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL sub_result: we=%b data=%h z=%b c=%b expected we=1 data=fffe z=0 c=1",
               MemWrite, MemData, ZeroFlag, CarryFlag);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_gap: busy got %b expected 0", busy);
    end
    issue(8'h06, 16'h0001, 16'h0013, 16'h0042);
    tick();
    n_checks++;
    if ({MemWrite, MemAddr, MemData, ZeroFlag, CarryFlag} !== {1'b1, 16'h0042, 16'h0008, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL shl_result: we=%b addr=%h data=%h z=%b c=%b expected we=1 addr=0042 data=0008 z=0 c=0",
               MemWrite, MemAddr, MemData, ZeroFlag, CarryFlag);
    end
    tick();
  endtask

  task automatic test_nop();
    issue(8'h02, 16'h0003, 16'h0005, 16'h0050);
    tick(); tick();
    issue(8'h00, 16'h1234, 16'h0001, 16'h0060);
    tick();
    n_checks++;
    if ({done, MemWrite, Illegal} !== 3'b100) begin
      n_fail++;
      $display("FAIL nop_strobes: done/we/ill got %b expected 100", {done, MemWrite, Illegal});
    end
    n_checks++;
    if ({ResultValue, ZeroFlag, CarryFlag} !== {16'hFFFE, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL nop_hold: result=%h z=%b c=%b expected fffe 0 1", ResultValue, ZeroFlag, CarryFlag);
    end
    tick();
  endtask

  task automatic test_illegal();
    logic [7:0] ops [2];
    int unsigned n_ops;
    ops[0] = 8'h7F;
    ops[1] = 8'h08;
`ifdef STAGE3_MUL_EN
    n_ops = 1;
`else
    n_ops = 2;
`endif
    for (int unsigned i = 0; i < n_ops; i++) begin
      issue(ops[i], 16'h0007, 16'h0003, 16'h0070);
      n_checks++;
      if ({done, Illegal} !== 2'b00) begin
        n_fail++;
        $display("FAIL illegal_cycle1 op=%h: done/ill got %b expected 00", ops[i], {done, Illegal});
      end
      tick();
      n_checks++;
      if ({done, MemWrite, Illegal} !== 3'b101) begin
        n_fail++;
        $display("FAIL illegal_strobes op=%h: done/we/ill got %b expected 101", ops[i], {done, MemWrite, Illegal});
      end
      n_checks++;
      if ({ResultValue, ZeroFlag, CarryFlag} !== {16'hFFFE, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL illegal_hold op=%h: result=%h z=%b c=%b expected fffe 0 1",
                 ops[i], ResultValue, ZeroFlag, CarryFlag);
      end
      tick();
      n_checks++;
      if (Illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_pulse op=%h: ill got %b expected 0", ops[i], Illegal);
      end
    end
  endtask

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        z;
    logic        c;
  } vec_t;

  task automatic test_alu_ops();
    vec_t v [11];
    v[0]  = '{8'h02, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1};
    v[1]  = '{8'h03, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
    v[2]  = '{8'h04, 16'hF0F0, 16'h0F01, 16'hFFF1, 1'b0, 1'b0};
    v[3]  = '{8'h05, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0};
    v[4]  = '{8'h07, 16'h8000, 16'h0024, 16'h0800, 1'b0, 1'b0};
    v[5]  = '{8'h06, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0};
    v[6]  = '{8'h07, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0};
    v[7]  = '{8'h01, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
    v[8]  = '{8'h02, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
    v[9]  = '{8'h02, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0};
    v[10] = '{8'h09, 16'h5A5A, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0};
    for (int unsigned i = 0; i < 11; i++) begin
      issue(v[i].op, v[i].a, v[i].b, 16'h0100 + 16'(i));
      tick();
      n_checks++;
      if ({MemWrite, MemAddr, MemData, ZeroFlag, CarryFlag} !==
          {1'b1, 16'h0100 + 16'(i), v[i].r, v[i].z, v[i].c}) begin
        n_fail++;
        $display("FAIL alu_vec%0d op=%h: we=%b addr=%h data=%h z=%b c=%b expected we=1 addr=%h data=%h z=%b c=%b",
                 i, v[i].op, MemWrite, MemAddr, MemData, ZeroFlag, CarryFlag,
                 16'h0100 + 16'(i), v[i].r, v[i].z, v[i].c);
      end
      tick();
    end
  endtask

`ifdef STAGE3_MUL_EN
  task automatic test_mul();
    int busy_cnt = 0;
    int we_cnt = 0;
    int we_cyc = -1;
    logic [15:0] we_data = '0;
    logic [15:0] we_addr = '0;
    issue(8'h08, 16'h0123, 16'h0100, 16'h0070);
    for (int cyc = 1; cyc <= 24; cyc++) begin
      if (busy === 1'b1) busy_cnt++;
      if (MemWrite === 1'b1) begin
        we_cnt++;
        we_cyc  = cyc;
        we_data = MemData;
        we_addr = MemAddr;
      end
      if (cyc == 5) begin
        OpIn = 8'h01; AIn = 16'hFFFF; BIn = 16'h0001; DestIn = 16'h0099;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    n_checks++;
    if (busy_cnt != 18) begin
      n_fail++;
      $display("FAIL mul_busy_cycles: got %0d expected 18", busy_cnt);
    end
    n_checks++;
    if (we_cnt != 1 || we_cyc != 18) begin
      n_fail++;
      $display("FAIL mul_write_cycle: writes=%0d cycle=%0d expected 1 write in cycle 18", we_cnt, we_cyc);
    end
    n_checks++;
    if ({we_addr, we_data} !== {16'h0070, 16'h2300}) begin
      n_fail++;
      $display("FAIL mul_result: addr=%h data=%h expected 0070 2300", we_addr, we_data);
    end
    n_checks++;
    if ({ResultValue, ZeroFlag, CarryFlag} !== {16'h2300, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mul_flags: result=%h z=%b c=%b expected 2300 0 0", ResultValue, ZeroFlag, CarryFlag);
    end
  endtask
`endif

  task automatic test_reset_mid_op();
    int stray = 0;
`ifdef STAGE3_MUL_EN
    issue(8'h08, 16'h0123, 16'h0100, 16'h0080);
    repeat (8) tick();
`else
    issue(8'h01, 16'hFFFF, 16'h0001, 16'h0080);
`endif
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_busy: got %b expected 1", busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({busy, done, MemWrite, Illegal, ZeroFlag, CarryFlag, MemAddr, MemData, ResultValue} !== 54'h0) begin
      n_fail++;
      $display("FAIL midop_reset_clear: ctrl=%b addr=%h data=%h result=%h expected all 0",
               {busy, done, MemWrite, Illegal, ZeroFlag, CarryFlag}, MemAddr, MemData, ResultValue);
    end
    for (int i = 0; i < 20; i++) begin
      if (MemWrite !== 1'b0 || busy !== 1'b0) stray++;
      tick();
    end
    n_checks++;
    if (stray != 0) begin
      n_fail++;
      $display("FAIL midop_no_write: stray active cycles got %0d expected 0", stray);
    end
    issue(8'h09, 16'hBEEF, 16'h1111, 16'h0090);
    tick();
    n_checks++;
    if ({MemWrite, done, MemAddr, MemData, ZeroFlag, CarryFlag} !== {1'b1, 1'b1, 16'h0090, 16'hBEEF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mov_after_reset: we=%b done=%b addr=%h data=%h z=%b c=%b expected 1 1 0090 beef 0 0",
               MemWrite, done, MemAddr, MemData, ZeroFlag, CarryFlag);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_nop();
    test_illegal();
    test_alu_ops();
`ifdef STAGE3_MUL_EN
    test_mul();
`endif
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_3.md
# stage_3

Execute/write-back stage of the memory-to-memory pipeline. Consumes the A, B, Dest and Op values registered by stage 2, computes the result, and issues one memory write of the result to address Dest. Single-cycle ALU ops and an optional iterative 16-cycle multiply share one FSM. The registered result is fed back to stage 2 as its `valA1` forwarding input.

## Interface
Parameters:
- None. Width is fixed at 16-bit data/address and 8-bit opcode.

Ports:
- `CLK` input 1: clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: operands valid. Sampled only in IDLE.
- `AIn` input 16: operand A, from stage 2 `AOutputValue`.
- `BIn` input 16: operand B, from stage 2 `BOutputValue`.
- `DestIn` input 16: destination address, from stage 2 `DestOutputValue`.
- `OpIn` input 8: opcode, from stage 2 `OpOutputValue`.
- `busy` output 1: high in EXEC, MUL and WRITE.
- `done` output 1: one-cycle pulse in WRITE.
- `MemWrite` output 1: memory write strobe, one cycle.
- `MemAddr` output 16: write address, the latched Dest.
- `MemData` output 16: write data, the result register.
- `ResultValue` output 16: result register, forwarded to stage 2 `valA1`.
- `ZeroFlag` output 1: registered; set when the result is 0.
- `CarryFlag` output 1: registered carry/borrow.
- `Illegal` output 1: one-cycle pulse for an undefined opcode.

## Operation
- Opcodes:
  - `0x00` NOP
  - `0x01` ADD A+B
  - `0x02` SUB A−B
  - `0x03` AND
  - `0x04` OR
  - `0x05` XOR
  - `0x06` SHL A<<B[3:0]
  - `0x07` SHR (logical) A>>B[3:0]
  - `0x08` MUL, low 16 bits of A×B
  - `0x09` MOV (result = A)
  - Any other value is illegal.
- FSM states: IDLE, EXEC, MUL, WRITE.
- IDLE: when `start`=1, latch AIn, BIn, DestIn and OpIn into internal registers, then go to EXEC. When `start`=0, stay in IDLE.
- EXEC:
  - For opcodes `0x01`–`0x07` and `0x09`, register the result and flags, then go to WRITE.
  - For MUL, clear the accumulator, load the 4-bit counter with 0, then go to MUL.
  - For NOP or an illegal opcode, the result register holds its value; go to WRITE.
- MUL: each cycle, if B bit 0 = 1, add A to the accumulator. Then shift A left 1 and shift B right 1 (both internal copies). After counter = 15, register the result and flags, then go to WRITE.
- WRITE:
  - `done`=1 in every case.
  - `MemWrite`=1 only for a valid non-NOP opcode.
  - `Illegal`=1 only for an undefined opcode.
  - Next state is IDLE.
- Arithmetic rules:
  - All results are modulo 2^16.
  - ADD: carry = bit 16 of the 17-bit sum.
  - SUB: carry = 1 when A<B (borrow).
  - Logic ops, shifts, MUL and MOV: carry = 0.
  - Zero is updated for every op that writes; flags are unchanged for NOP and illegal.
  - Shift amounts of 0 pass A through unchanged.
- `start` while `busy`=1 is ignored; stage 2 must hold its values until `done`.
- `reset` clears to 0: state (IDLE), counter, latched operands, result, `MemWrite`, `done`, `busy`, `Illegal`, both flags, `MemAddr` and `MemData`.
- `reset` asserted mid-operation, including during MUL or WRITE, aborts the operation; no write is issued on that edge.

## Timing
- Single-cycle op: `start` sampled at edge 0 → EXEC in cycle 1 → WRITE in cycle 2 (`MemWrite`/`done` high) → IDLE in cycle 3. Latency is 2 cycles from the `start` edge to `MemWrite`.
- MUL: EXEC in cycle 1, MUL in cycles 2–17, WRITE in cycle 18. Latency is 18 cycles.
- `ResultValue` is valid from the WRITE cycle onward and holds until the next operation's EXEC or MUL completes.
- The earliest back-to-back `start` is accepted in the IDLE cycle immediately after WRITE, so the throughput is one op per 3 cycles.

## Configuration
- `STAGE3_MUL_EN` defined: the multiplier datapath, the 4-bit counter and the MUL state are compiled in, and MUL behaves as above.
- `STAGE3_MUL_EN` undefined: no multiplier hardware is built and `0x08` is treated as illegal. The sequence is EXEC → WRITE with `Illegal`=1, `MemWrite`=0 and a 2-cycle latency.

## Test plan
- Reset, then ADD with A=`0xFFFF`, B=`0x0001`, Dest=`0x0040`:
  - WRITE occurs 2 cycles after `start`.
  - `MemAddr`=`0x0040`, `MemData`=`0x0000`, `ZeroFlag`=1, `CarryFlag`=1.
- SUB with A=`0x0003`, B=`0x0005`: `MemData`=`0xFFFE`, `CarryFlag`=1, `ZeroFlag`=0. Then SHL with A=`0x0001`, B=`0x0013`: `MemData`=`0x0008`.
- With `STAGE3_MUL_EN` defined, MUL with A=`0x0123`, B=`0x0100`:
  - `busy` is high for 18 cycles.
  - `MemWrite` occurs in cycle 18 with `MemData`=`0x2300`.
  - A second `start` pulsed during cycle 5 is ignored.
- With `STAGE3_MUL_EN` undefined, opcode `0x08`: `Illegal` and `done` pulse in cycle 2, and `MemWrite` stays 0. With it defined, opcode `0x7F` gives the same response.
- NOP: `done`=1, `MemWrite`=0, and the flags and `ResultValue` are unchanged from the prior op.
- `reset` asserted in cycle 9 of a MUL:
  - All outputs read 0 on the next cycle and no write occurs.
  - A following MOV with A=`0xBEEF` completes normally with `MemData`=`0xBEEF`.
